// File: rtl/pipe_pkg.sv
// pipe_pkg: shared PC constants and the branch-prediction shadow entry
package pipe_pkg;

    localparam int PC_BITS = 32;
    localparam logic [PC_BITS-1:0] RESET_PC = '0;
    localparam logic [PC_BITS-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic               valid;
        logic [PC_BITS-1:0] pc;
        logic               pred_taken;
        logic [PC_BITS-1:0] pred_target;
    } shadow_t;

endpackage

// File: rtl/bp_shadow_stage.sv
// bp_shadow_stage: one pipeline slot carrying a fetched PC and its prediction
module bp_shadow_stage
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_hold,
    input  logic    i_clr,
    input  logic    i_load,
    input  shadow_t i_d,
    output shadow_t o_q
);

    shadow_t r_q;

    // hold beats clear beats load; clear only kills the valid bit
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (!i_hold) begin
            if (i_clr)
                r_q.valid <= 1'b0;
            else if (i_load)
                r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch PC register, prediction shadow pipe and EX mispredict redirect
module fetch_redirect_unit #(
    parameter int                 PC_BITS  = pipe_pkg::PC_BITS,
    parameter logic [PC_BITS-1:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter int                 CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                F_stall,
    input  logic                MEM_stall,
    input  logic [PC_BITS-1:0]  BP_target_pc,
    input  logic                BP_taken,
    input  logic                EX_brn,
    input  logic                EX_true_taken,
    input  logic [PC_BITS-1:0]  EX_alu_out,
    output logic [PC_BITS-1:0]  F_pc,
    output logic [PC_BITS-1:0]  EX_pc,
    output logic                EX_valid,
    output logic                BP_update,
    output logic                redirect,
    output logic [PC_BITS-1:0]  redirect_pc,
    output logic [CNT_BITS-1:0] branch_cnt,
    output logic [CNT_BITS-1:0] mispredict_cnt
);

    import pipe_pkg::*;

    logic [PC_BITS-1:0]  r_pc;
    logic [CNT_BITS-1:0] r_branch_cnt;
    logic [CNT_BITS-1:0] r_mispredict_cnt;
    shadow_t             w_d_in;
    shadow_t             w_d;
    shadow_t             w_ex;
    logic                w_br_miss;
    logic                w_ph_miss;

    assign w_d_in = '{valid: 1'b1, pc: r_pc, pred_taken: BP_taken, pred_target: BP_target_pc};

    bp_shadow_stage u_d (
        .clk    (clk),
        .rst    (rst),
        .i_hold (MEM_stall | (F_stall & ~redirect)),
        .i_clr  (redirect),
        .i_load (1'b1),
        .i_d    (w_d_in),
        .o_q    (w_d)
    );

    bp_shadow_stage u_ex (
        .clk    (clk),
        .rst    (rst),
        .i_hold (MEM_stall),
        .i_clr  (redirect | F_stall),
        .i_load (1'b1),
        .i_d    (w_d),
        .o_q    (w_ex)
    );

    assign w_br_miss = w_ex.valid & EX_brn &
                       ((EX_true_taken != w_ex.pred_taken) |
                        (EX_true_taken & (EX_alu_out != w_ex.pred_target)));
    assign w_ph_miss = w_ex.valid & ~EX_brn & w_ex.pred_taken;

    assign redirect    = w_br_miss | w_ph_miss;
    assign redirect_pc = (EX_brn & EX_true_taken) ? EX_alu_out : w_ex.pc + PC_STEP;
    assign BP_update   = EX_brn & w_ex.valid & ~MEM_stall;

    // fetch PC follows the predictor unless EX redirects it; a stall freezes it
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (!MEM_stall) begin
            if (redirect)
                r_pc <= redirect_pc;
            else if (!F_stall)
                r_pc <= BP_target_pc;
        end
    end

    // saturating statistics; redirects are counted only on the edge that acts on them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (BP_update && r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + CNT_BITS'(1);
            if (redirect && !MEM_stall && r_mispredict_cnt != '1)
                r_mispredict_cnt <= r_mispredict_cnt + CNT_BITS'(1);
        end
    end

    assign F_pc           = r_pc;
    assign EX_pc          = w_ex.pc;
    assign EX_valid       = w_ex.valid;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
